uart_trans: RTL and testbench

Serial transmitter paired with the team's UART receiver. It accepts a parallel word and asserts the `recSig` announce strobe for one bit period. After `leadCycles` bit periods have elapsed since the announce began, it shifts the word out LSB-first on `bsOut`, one bit per bit period. The shift order matches the receiver's MSB-loaded, right-shifting register, so bit 0 lands in `data[0]`. The block sits on the sending board, between the application logic and the serial wire.

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_baud_tick.sv | 38 +++
 rtl/uart_trans.sv | 125 ++++++++++++
 tb/tb_uart_trans.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding and default link parameters.
// Used by both the transmitter and the receiver side.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ANNOUNCE,
        LEAD,
        DATA
    } tx_state_t;

    localparam int UART_PACKET_SIZE = 16;
    localparam int UART_CYCLE_DIV   = 100;
    localparam int UART_LEAD_CYCLES = 3;

endpackage

// File: rtl/uart_baud_tick.sv
// Restartable bit-period divider: counts 0..cycleDiv-1 while enabled and flags the last cycle.
// The clear input re-phases the period to the cycle after it is asserted.
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int cycleDiv = UART_CYCLE_DIV
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic en,
    output logic tick
);

    localparam int CNT_W = (cycleDiv > 1) ? $clog2(cycleDiv) : 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign tick = en && (cnt_q == CNT_W'(cycleDiv - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clear || tick) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_trans.sv
// UART transmitter: announces a word on recSig, waits out the lead periods, then shifts
// the captured word onto bsOut LSB-first. All outputs come straight from flops.
module uart_trans
    import uart_pkg::*;
#(
    parameter int packetSize = UART_PACKET_SIZE,
    parameter int cycleDiv   = UART_CYCLE_DIV,
    parameter int leadCycles = UART_LEAD_CYCLES
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [packetSize-1:0] data,
    output logic                  busy,
    output logic                  done,
    output logic                  recSig,
    output logic                  bsOut
);

    localparam int BIT_W  = $clog2(packetSize + 1);
    localparam int LEAD_W = $clog2(leadCycles + 1);

    tx_state_t             state_q, state_d;
    logic [packetSize-1:0] shadow_q, shadow_d;
    logic [BIT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic [LEAD_W-1:0]     lead_cnt_q, lead_cnt_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  rec_sig_q, rec_sig_d;
    logic                  bs_out_q, bs_out_d;
    logic                  accept;
    logic                  tick;

    assign accept = (state_q == IDLE) && start;

    uart_baud_tick #(
        .cycleDiv(cycleDiv)
    ) u_baud_tick (
        .clk  (clk),
        .reset(reset),
        .clear(accept),
        .en   (state_q != IDLE),
        .tick (tick)
    );

    // NOTE: every variable gets its default first so no path through the case infers a latch.
    always_comb begin
        state_d    = state_q;
        shadow_d   = shadow_q;
        bit_cnt_d  = bit_cnt_q;
        lead_cnt_d = lead_cnt_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = ANNOUNCE;
                    shadow_d   = data;
                    bit_cnt_d  = '0;
                    lead_cnt_d = '0;
                end
            end
            ANNOUNCE: begin
                if (tick) begin
                    // lead_cnt counts completed pre-data periods, announce included.
                    lead_cnt_d = LEAD_W'(1);
                    state_d    = (leadCycles == 1) ? DATA : LEAD;
                end
            end
            LEAD: begin
                if (tick) begin
                    if (lead_cnt_q == LEAD_W'(leadCycles - 1)) begin
                        state_d = DATA;
                    end else begin
                        lead_cnt_d = lead_cnt_q + LEAD_W'(1);
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    shadow_d  = shadow_q >> 1;
                    bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    if (bit_cnt_q == BIT_W'(packetSize - 1)) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Outputs are decoded from next state so the flops present them in the state's first cycle.
        busy_d    = (state_d != IDLE);
        rec_sig_d = (state_d == ANNOUNCE);
        bs_out_d  = (state_d == DATA) && shadow_d[0];
        done_d    = (state_q == DATA) && (state_d == IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            shadow_q   <= '0;
            bit_cnt_q  <= '0;
            lead_cnt_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            rec_sig_q  <= 1'b0;
            bs_out_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            shadow_q   <= shadow_d;
            bit_cnt_q  <= bit_cnt_d;
            lead_cnt_q <= lead_cnt_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            rec_sig_q  <= rec_sig_d;
            bs_out_q   <= bs_out_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign recSig = rec_sig_q;
    assign bsOut  = bs_out_q;

endmodule

// File: tb/tb_uart_trans.sv
// Directed bench for uart_trans: a 16/4/3 instance for timing and control cases, a 1/2/1
// edge instance, and a 16/100/3 instance driven into a small receiver model for loopback.
module tb_uart_trans;

    logic clk;

    logic        rst_a, start_a, busy_a, done_a, rec_a, bs_a;
    logic [15:0] data_a;
    logic        rst_b, start_b, busy_b, done_b, rec_b, bs_b;
    logic [0:0]  data_b;
    logic        rst_c, start_c, busy_c, done_c, rec_c, bs_c;
    logic [15:0] data_c;

    int errors = 0;
    int checks = 0;

    uart_trans #(.packetSize(16), .cycleDiv(4), .leadCycles(3)) dut_a (
        .clk(clk), .reset(rst_a), .start(start_a), .data(data_a),
        .busy(busy_a), .done(done_a), .recSig(rec_a), .bsOut(bs_a)
    );

    uart_trans #(.packetSize(1), .cycleDiv(2), .leadCycles(1)) dut_b (
        .clk(clk), .reset(rst_b), .start(start_b), .data(data_b),
        .busy(busy_b), .done(done_b), .recSig(rec_b), .bsOut(bs_b)
    );

    uart_trans #(.packetSize(16), .cycleDiv(100), .leadCycles(3)) dut_c (
        .clk(clk), .reset(rst_c), .start(start_c), .data(data_c),
        .busy(busy_c), .done(done_c), .recSig(rec_c), .bsOut(bs_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // One full 16/4/3 transfer checked cycle by cycle; returns in the done cycle (cycle 77).
    task automatic xfer_a(input logic [15:0] word, input bit hold, input bit poke);
        logic exp_bs;
        data_a  = word;
        start_a = 1'b1;
        step();
        if (!hold) start_a = 1'b0;
        for (int c = 1; c <= 77; c++) begin
            exp_bs = (c >= 13 && c <= 76) ? word[(c - 13) / 4] : 1'b0;
            check($sformatf("a_recSig c%0d", c), 32'(rec_a),  32'(c <= 4));
            check($sformatf("a_busy c%0d", c),   32'(busy_a), 32'(c <= 76));
            check($sformatf("a_done c%0d", c),   32'(done_a), 32'(c == 77));
            check($sformatf("a_bsOut c%0d", c),  32'(bs_a),   32'(exp_bs));
            if (poke) begin
                start_a = (c == 20 || c == 40);
                if (c == 20) data_a = ~word;
                if (c == 40) data_a = 16'h0F0F;
            end
            if (c < 77) step();
        end
    endtask

    // Receiver model: samples mid-bit and loads at the MSB while shifting right.
    task automatic xfer_c(input logic [15:0] word);
        logic [15:0] rx;
        int          done_cycle;
        rx         = '0;
        done_cycle = 0;
        data_c     = word;
        start_c    = 1'b1;
        step();
        start_c = 1'b0;
        check("c_recSig_first", 32'(rec_c), 32'd1);
        for (int c = 1; c <= 2100; c++) begin
            if (c >= 301 && ((c - 301) % 100) == 50) rx = {bs_c, rx[15:1]};
            if (done_c) begin
                done_cycle = c;
                break;
            end
            step();
        end
        check($sformatf("c_done_cycle %h", word), done_cycle, 32'd1901);
        check($sformatf("c_rx_word %h", word), 32'(rx), 32'(word));
    endtask

    initial begin
        int done_seen;
        int busy_seen;

        rst_a = 1'b1; start_a = 1'b0; data_a = '0;
        rst_b = 1'b1; start_b = 1'b0; data_b = '0;
        rst_c = 1'b1; start_c = 1'b0; data_c = '0;
        step();
        step();
        check("reset_a_outs", 32'({busy_a, done_a, rec_a, bs_a}), 32'd0);
        check("reset_b_outs", 32'({busy_b, done_b, rec_b, bs_b}), 32'd0);
        check("reset_c_outs", 32'({busy_c, done_c, rec_c, bs_c}), 32'd0);
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
        step();
        check("idle_a_outs", 32'({busy_a, done_a, rec_a, bs_a}), 32'd0);

        // Basic timing with the reference word.
        xfer_a(16'hA5C3, 1'b0, 1'b0);
        step();
        check("a_idle_after", 32'({busy_a, done_a, rec_a, bs_a}), 32'd0);

        // Mid-transfer start pulses and data changes must be ignored.
        xfer_a(16'h3C96, 1'b0, 1'b1);
        done_seen = 0;
        busy_seen = 0;
        for (int i = 0; i < 90; i++) begin
            step();
            if (done_a) done_seen++;
            if (busy_a) busy_seen++;
        end
        check("a_poke_no_second_done", done_seen, 32'd0);
        check("a_poke_no_second_busy", busy_seen, 32'd0);

        // start held high: back-to-back with done cycle serving as acceptance.
        xfer_a(16'h1357, 1'b1, 1'b0);
        xfer_a(16'h2468, 1'b0, 1'b0);
        step();
        check("a_b2b_idle", 32'({busy_a, done_a, rec_a, bs_a}), 32'd0);

        // Reset in DATA while bit 5 is on the line.
        data_a  = 16'hFFFF;
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        for (int c = 1; c < 34; c++) step();
        check("a_bit5_before_reset", 32'(bs_a), 32'd1);
        check("a_busy_before_reset", 32'(busy_a), 32'd1);
        rst_a = 1'b1;
        step();
        check("a_outs_after_reset", 32'({busy_a, done_a, rec_a, bs_a}), 32'd0);
        rst_a = 1'b0;
        done_seen = 0;
        busy_seen = 0;
        for (int i = 0; i < 90; i++) begin
            step();
            if (done_a) done_seen++;
            if (busy_a) busy_seen++;
        end
        check("a_no_done_after_reset", done_seen, 32'd0);
        check("a_no_busy_after_reset", busy_seen, 32'd0);
        xfer_a(16'h5A3C, 1'b0, 1'b0);

        // Edge parameters 1/2/1.
        data_b  = 1'b1;
        start_b = 1'b1;
        step();
        start_b = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            check($sformatf("b_recSig c%0d", c), 32'(rec_b),  32'(c <= 2));
            check($sformatf("b_bsOut c%0d", c),  32'(bs_b),   32'(c == 3 || c == 4));
            check($sformatf("b_done c%0d", c),   32'(done_b), 32'(c == 5));
            check($sformatf("b_busy c%0d", c),   32'(busy_b), 32'(c <= 4));
            step();
        end

        // Loopback into the receiver model at 16/100/3.
        xfer_c(16'h0001);
        xfer_c(16'h8000);
        xfer_c(16'hFFFF);
        xfer_c(16'h1234);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
